// File: rtl/comp_serial_msb.sv
// -----------------------------------------------------------------------------
// comp_serial_msb
//
// Chunk-serial unsigned magnitude comparator. Operands A and B arrive as
// CH = N/W chunk pairs of W bits each, most-significant chunk first, over a
// valid/ready stream. The direction of the comparison is fixed by the first
// chunk pair that differs; later chunks are still consumed but cannot change
// the outcome. After the last chunk the result (ge/eq/gt) is presented on a
// registered valid/ready output and held until the consumer takes it.
//
// Parameters
//   N          total operand width in bits (multiple of W, N >= W)
//   W          chunk width in bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   a_chunk/b_chunk carry a valid chunk pair
//   in_ready   block accepts a chunk pair this cycle (high only in RUN)
//   a_chunk    current chunk of A, MSB chunk first
//   b_chunk    current chunk of B, same chunk index as a_chunk
//   out_valid  result is valid
//   out_ready  consumer takes the result
//   ge         A >= B (unsigned); 0 while out_valid is 0
//   eq         A == B;            0 while out_valid is 0
//   gt         A >  B (unsigned); 0 while out_valid is 0
// -----------------------------------------------------------------------------
module comp_serial_msb #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_chunk,
    input  logic [W-1:0] b_chunk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ge,
    output logic         eq,
    output logic         gt
);

    // Number of chunks per operand and the width of the chunk counter.
    // A single-chunk configuration still needs a 1-bit counter to keep the
    // datapath well formed; it simply never leaves zero.
    localparam int CH = N / W;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(CH - 1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Fold one chunk pair into the running decision.
    // Returns {decided, a_gt} after this chunk. Once a decision exists it is
    // sticky: the incoming chunk only matters while all higher chunks matched.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] fold_chunk(
        input logic         decided_in,
        input logic         a_gt_in,
        input logic [W-1:0] a_in,
        input logic [W-1:0] b_in
    );
        logic [1:0] res;
        if (decided_in) begin
            res = {1'b1, a_gt_in};
        end else if (a_in != b_in) begin
            res = {1'b1, (a_in > b_in)};
        end else begin
            res = {1'b0, 1'b0};
        end
        return res;
    endfunction

    // Registered state
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          decided_r;
    logic          a_gt_r;
    logic          out_valid_r;
    logic          ge_r;
    logic          eq_r;
    logic          gt_r;

    // Next-state values
    state_t        state_s;
    logic [CW-1:0] cnt_s;
    logic          decided_s;
    logic          a_gt_s;
    logic          out_valid_s;
    logic          ge_s;
    logic          eq_s;
    logic          gt_s;

    // Helpers
    logic          accept_s;
    logic          last_s;
    logic [1:0]    fold_s;
    logic          fold_decided_s;
    logic          fold_a_gt_s;

    // in_ready is a pure state decode, so no input reaches an output
    // combinationally.
    assign in_ready       = (state_r == RUN);
    assign accept_s       = in_valid & in_ready;
    assign last_s         = (cnt_r == LAST_IDX);
    assign fold_s         = fold_chunk(decided_r, a_gt_r, a_chunk, b_chunk);
    assign fold_decided_s = fold_s[1];
    assign fold_a_gt_s    = fold_s[0];

    assign out_valid = out_valid_r;
    assign ge        = ge_r;
    assign eq        = eq_r;
    assign gt        = gt_r;

    // Next-state and result computation for the RUN/DONE controller.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        decided_s   = decided_r;
        a_gt_s      = a_gt_r;
        out_valid_s = out_valid_r;
        ge_s        = ge_r;
        eq_s        = eq_r;
        gt_s        = gt_r;

        case (state_r)
            RUN: begin
                if (accept_s) begin
                    if (last_s) begin
                        // Final chunk: publish the decision including this
                        // chunk and clear the per-operation scan state so the
                        // next operation starts clean.
                        gt_s        = fold_decided_s & fold_a_gt_s;
                        eq_s        = ~fold_decided_s;
                        ge_s        = (fold_decided_s & fold_a_gt_s) | ~fold_decided_s;
                        out_valid_s = 1'b1;
                        state_s     = DONE;
                        cnt_s       = {CW{1'b0}};
                        decided_s   = 1'b0;
                        a_gt_s      = 1'b0;
                    end else begin
                        // Every chunk is counted, even after an early decision,
                        // so the stream framing never depends on the data.
                        cnt_s     = cnt_r + CW'(1);
                        decided_s = fold_decided_s;
                        a_gt_s    = fold_a_gt_s;
                    end
                end else begin
                    // Input gap: nothing advances.
                    state_s = RUN;
                end
            end

            DONE: begin
                if (out_ready) begin
                    // Result taken: outputs read zero again and RUN resumes on
                    // the next cycle (no same-cycle accept in DONE).
                    state_s     = RUN;
                    out_valid_s = 1'b0;
                    ge_s        = 1'b0;
                    eq_s        = 1'b0;
                    gt_s        = 1'b0;
                end else begin
                    // Backpressure: hold the result stable.
                    state_s = DONE;
                end
            end

            default: begin
                // Unreachable encoding: fall back to the reset condition.
                state_s     = RUN;
                cnt_s       = {CW{1'b0}};
                decided_s   = 1'b0;
                a_gt_s      = 1'b0;
                out_valid_s = 1'b0;
                ge_s        = 1'b0;
                eq_s        = 1'b0;
                gt_s        = 1'b0;
            end
        endcase
    end

    // State, scan and result registers; reset discards any partial operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            cnt_r       <= {CW{1'b0}};
            decided_r   <= 1'b0;
            a_gt_r      <= 1'b0;
            out_valid_r <= 1'b0;
            ge_r        <= 1'b0;
            eq_r        <= 1'b0;
            gt_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            decided_r   <= decided_s;
            a_gt_r      <= a_gt_s;
            out_valid_r <= out_valid_s;
            ge_r        <= ge_s;
            eq_r        <= eq_s;
            gt_r        <= gt_s;
        end
    end

endmodule

// File: tb/tb_comp_serial_msb.sv
// -----------------------------------------------------------------------------
// Testbench for comp_serial_msb. A 32/8 instance is driven with directed and
// randomized operations (random in_valid gaps and output backpressure); a
// second 8/8 instance exercises the single-chunk back-to-back case. Expected
// results come from whole-operand integer comparison.
// -----------------------------------------------------------------------------
module tb_comp_serial_msb;

    localparam int N  = 32;
    localparam int W  = 8;
    localparam int CH = N / W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_chunk;
    logic [W-1:0] b_chunk;
    logic         out_valid;
    logic         out_ready;
    logic         ge;
    logic         eq;
    logic         gt;

    logic         in_valid1;
    logic         in_ready1;
    logic [7:0]   a_chunk1;
    logic [7:0]   b_chunk1;
    logic         out_valid1;
    logic         out_ready1;
    logic         ge1;
    logic         eq1;
    logic         gt1;

    int n_checks = 0;
    int n_errors = 0;
    int gap_pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    comp_serial_msb #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_chunk   (a_chunk),
        .b_chunk   (b_chunk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ge        (ge),
        .eq        (eq),
        .gt        (gt)
    );

    comp_serial_msb #(.N(8), .W(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a_chunk   (a_chunk1),
        .b_chunk   (b_chunk1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .ge        (ge1),
        .eq        (eq1),
        .gt        (gt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation on the 32/8 instance. gap_pct: chance (%) of an idle
    // in_valid cycle; use_pat selects the fixed gap pattern instead; hold is the
    // number of DONE cycles with out_ready low before the handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int gap_pct, input bit use_pat, input int hold,
                          input int exp_cycles);
        int  idx;
        int  cyc;
        bit  acc;
        logic exp_ge;
        logic exp_eq;
        logic exp_gt;
        exp_ge = (a >= b);
        exp_eq = (a == b);
        exp_gt = (a > b);
        idx = 0;
        cyc = 0;
        out_ready = (hold == 0);
        while (idx < CH && cyc < 200) begin
            @(negedge clk);
            check_val("run_out_valid", {31'd0, out_valid}, 32'd0);
            check_val("run_in_ready", {31'd0, in_ready}, 32'd1);
            if (use_pat) in_valid = (gap_pat[cyc % 7] != 0);
            else         in_valid = ($urandom_range(99) >= gap_pct);
            a_chunk = a[(CH-1-idx)*W +: W];
            b_chunk = b[(CH-1-idx)*W +: W];
            acc = in_valid & in_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        check_val("accepts", idx, CH);
        if (exp_cycles > 0) check_val("accept_cycles", cyc, exp_cycles);
        @(negedge clk);
        in_valid = 1'b0;
        a_chunk  = W'($urandom);
        b_chunk  = W'($urandom);
        check_val("done_out_valid", {31'd0, out_valid}, 32'd1);
        check_val("done_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("done_ge", {31'd0, ge}, {31'd0, exp_ge});
        check_val("done_eq", {31'd0, eq}, {31'd0, exp_eq});
        check_val("done_gt", {31'd0, gt}, {31'd0, exp_gt});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("hold_result", {29'd0, ge, eq, gt}, {29'd0, exp_ge, exp_eq, exp_gt});
            if (k == hold - 1) out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("after_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("after_result", {29'd0, ge, eq, gt}, 32'd0);
        check_val("after_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  q1[$];
        logic [2:0]  e1;
        bit          pend1;
        int          results1;
        int          sel;

        rst_n      = 1'b0;
        in_valid   = 1'b1;
        a_chunk    = 8'hA5;
        b_chunk    = 8'h5A;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        a_chunk1   = 8'd0;
        b_chunk1   = 8'd0;
        out_ready1 = 1'b0;

        // Reset state (inputs toggling/ignored while held in reset)
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_result", {29'd0, ge, eq, gt}, 32'd0);
        check_val("rst1_in_ready", {31'd0, in_ready1}, 32'd1);
        check_val("rst1_out_valid", {31'd0, out_valid1}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed cases
        run_op(32'h12345678, 32'h12345678, 0, 1'b0, 0, 4);
        run_op(32'h80000000, 32'h7FFFFFFF, 0, 1'b0, 0, 4);
        run_op(32'h00000001, 32'h00000002, 0, 1'b0, 0, 4);
        run_op(32'h000000FF, 32'h00000001, 0, 1'b0, 3, 4);
        run_op(32'h80000000, 32'h7FFFFFFF, 0, 1'b1, 0, 7);

        // Reset mid-operation after two chunks
        ra = 32'hAAAAAAAA;
        rb = 32'h55555555;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_chunk  = ra[(CH-1-i)*W +: W];
            b_chunk  = rb[(CH-1-i)*W +: W];
            @(posedge clk);
        end
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h00000010, 32'h00000010, 0, 1'b0, 0, 4);

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(2);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 1) rb = ra;
            if (sel == 2) begin
                rb = ra;
                rb[$urandom_range(CH-1)*W +: W] = 8'($urandom);
            end
            run_op(ra, rb, $urandom_range(50), 1'b0, $urandom_range(2), 0);
        end

        // Single-chunk instance: back-to-back, a result every 2 cycles
        q1       = {};
        pend1    = 1'b0;
        results1 = 0;
        @(negedge clk);
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            check_val("ch1_out_valid", {31'd0, out_valid1}, {31'd0, pend1});
            if (out_valid1) begin
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    check_val("ch1_result", {29'd0, ge1, eq1, gt1}, {29'd0, e1});
                end
                results1++;
            end
            a_chunk1 = 8'($urandom);
            b_chunk1 = ($urandom_range(3) == 0) ? a_chunk1 : 8'($urandom);
            pend1 = in_valid1 & in_ready1;
            if (pend1) q1.push_back({a_chunk1 >= b_chunk1, a_chunk1 == b_chunk1, a_chunk1 > b_chunk1});
            @(posedge clk);
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        check_val("ch1_results", results1, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
